// File: rtl/seq_divider_if.sv
// Handshake and result bus between a requester and the sequential divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 10
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, unsigned or two's-complement.
// Results and flags are held until the FIX step of the next accepted operation.
module seq_divider #(
  parameter int unsigned WIDTH = 10
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_raw;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;
  logic             dz_pend;
  logic             ovf_pend;

  logic             neg_a_c;
  logic             neg_b_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   rem_shift_c;
  logic [WIDTH:0]   trial_c;

  // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
  assign neg_a_c = bus.signed_mode & bus.a[WIDTH-1];
  assign neg_b_c = bus.signed_mode & bus.b[WIDTH-1];
  assign a_mag_c = neg_a_c ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag_c = neg_b_c ? (~bus.b + WIDTH'(1)) : bus.b;

  // Trial subtraction; the partial remainder stays below the divisor, so the
  // top bit of the difference is the borrow (set when the divisor does not fit).
  assign rem_shift_c = {rem, dvd[WIDTH-1]};
  assign trial_c     = rem_shift_c - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      dvd             <= '0;
      dvs             <= '0;
      rem             <= '0;
      a_raw           <= '0;
      count           <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      dz_pend         <= 1'b0;
      ovf_pend        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          if (bus.start) begin
            a_raw    <= bus.a;
            dvd      <= a_mag_c;
            dvs      <= b_mag_c;
            rem      <= '0;
            count    <= CW'(WIDTH);
            neg_q    <= neg_a_c ^ neg_b_c;
            neg_r    <= neg_a_c;
            dz_pend  <= (bus.b == '0);
            ovf_pend <= bus.signed_mode
                        && (bus.a == {1'b1, {(WIDTH-1){1'b0}}})
                        && (bus.b == '1);
            bus.busy <= 1'b1;
            state    <= (bus.b == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          rem   <= trial_c[WIDTH] ? rem_shift_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], ~trial_c[WIDTH]};
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (dz_pend) begin
            bus.quotient  <= '1;
            bus.remainder <= a_raw;
          end else begin
            bus.quotient  <= neg_q ? (~dvd + WIDTH'(1)) : dvd;
            bus.remainder <= neg_r ? (~rem + WIDTH'(1)) : rem;
          end
          bus.div_by_zero <= dz_pend;
          bus.overflow    <= ovf_pend;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          state           <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 10, operand and result width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled on the rising edge of clk.
REQ-005 signed_mode  input  1  0 = unsigned, 1 = two's-complement operands; sampled with start.
REQ-006 a  input  WIDTH  dividend; sampled with start.
REQ-007 b  input  WIDTH  divisor; sampled with start.
REQ-008 busy  output  1  high from the edge that accepts start until the edge that asserts done.
REQ-009 done  output  1  single-cycle pulse; results valid.
REQ-010 quotient  output  WIDTH  registered quotient; held until the next accepted start.
REQ-011 remainder  output  WIDTH  registered remainder; held until the next accepted start.
REQ-012 div_by_zero  output  1  registered flag, valid with done; held like quotient.
REQ-013 overflow  output  1  registered signed-overflow flag, valid with done; held like quotient.

Function
REQ-014 The block SHALL use the states IDLE, RUN, FIX and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-015 A start SHALL be accepted only when busy=0 (IDLE or DONE); start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-016 On acceptance the block SHALL:
- latch a, b and signed_mode;
- if signed, convert the operands to magnitudes and record the result signs;
- clear the partial remainder;
- go to RUN, or go to FIX directly if b=0.
REQ-017 RUN SHALL perform radix-2 restoring division, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, then go to FIX.
REQ-018 In FIX the block SHALL apply sign correction and load quotient, remainder and the flags in one cycle, then go to DONE with done=1.
REQ-019 Latency SHALL be: start accepted at edge k -> done high after edge k+WIDTH+1 (b≠0) or after edge k+1 (b=0).
REQ-020 Unsigned results SHALL be q=floor(a/b) and r=a mod b.
REQ-021 Signed results SHALL truncate toward zero; the remainder takes the sign of the dividend, and |r|<|b|.
REQ-022 For b=0 the block SHALL output quotient = all ones, remainder = a (unmodified) and div_by_zero=1, in both modes.
REQ-023 In signed mode, a = most-negative and b = -1 SHALL give quotient = most-negative, remainder=0, overflow=1.
REQ-024 overflow SHALL be 0 in unsigned mode; div_by_zero and overflow SHALL be 0 for every other operand pair.
REQ-025 Internal datapath width SHALL be WIDTH+1 bits for the trial subtraction; no wider arithmetic is permitted.
REQ-026 A start accepted in the DONE cycle SHALL begin a new operation back-to-back; the previous results remain on the outputs until the new FIX.
REQ-027 All outputs SHALL be registered; done and busy SHALL never be high together.

Reset
REQ-028 When rst_n=0 the block SHALL immediately go to IDLE, with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave normally.
REQ-030 The deassertion of rst_n is synchronised externally; the block SHALL accept start on the first rising edge after deassertion.

Verification
REQ-031 WIDTH=10, unsigned, a=1000, b=7 -> done after 11 edges; q=142, r=6, flags 0.
REQ-032 Signed, a=-100 (0x39C), b=7 -> q=-14 (0x3F2), r=-2 (0x3FE); separately, a=100, b=-7 -> q=-14, r=2.
REQ-033 a=5, b=0 (both modes) -> done after 1 edge; q=0x3FF, r=5, div_by_zero=1.
REQ-034 Signed, a=-512 (0x200), b=-1 -> q=0x200, r=0, overflow=1.
REQ-035 Start pulsed again mid-RUN -> ignored, and the original result arrives on time; start in the DONE cycle -> second result after a further 11 edges.
REQ-036 rst_n pulsed low at RUN cycle 4 -> all outputs 0 immediately, no done; the next start produces the correct result.
